// File: rtl/aes_byte_feeder_if.sv
// Byte stream in / (key, plaintext) pair stream out between the feeder and its neighbours.
// The feeder takes the slave view; the upstream/downstream environment takes the master view.
interface aes_byte_feeder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_key;
  logic [7:0] out_pt;
  logic [3:0] out_idx;
  logic       out_last;
  logic       sel_in;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_key, out_pt, out_idx, out_last, sel_in
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_key, out_pt, out_idx, out_last, sel_in
  );
endinterface

// File: rtl/aes_byte_feeder.sv
// Stages 16 key bytes then 16 plaintext bytes from a byte stream and drains them
// as aligned (key, plaintext) pairs into the AES datapath input muxes.
module aes_byte_feeder (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  aes_byte_feeder_if.slave       io,
  output logic                   busy,
  output logic [7:0]             blk_cnt
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NBYTES = 16;
  localparam int unsigned WP_W   = 5;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {LOAD_KEY, LOAD_PT, DRAIN} state_t;

  state_t            state;
  logic [WP_W-1:0]   wp;
  logic [IDX_W-1:0]  rp;
  logic [IDX_W-1:0]  rp_nxt;
  logic [BYTE_W-1:0] key [NBYTES];
  logic [BYTE_W-1:0] pt  [NBYTES];

  assign rp_nxt = rp + IDX_W'(1);

  // Single-process FSM; every output is a flop updated together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD_KEY;
      wp           <= '0;
      rp           <= '0;
      for (int i = 0; i < NBYTES; i++) begin
        key[i] <= '0;
        pt[i]  <= '0;
      end
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out_key   <= '0;
      io.out_pt    <= '0;
      io.out_idx   <= '0;
      io.out_last  <= 1'b0;
      io.sel_in    <= 1'b0;
      busy         <= 1'b0;
      blk_cnt      <= '0;
    end else if (flush) begin
      // Abort wins over any handshake this cycle; buffer and blk_cnt are kept.
      state        <= LOAD_KEY;
      wp           <= '0;
      rp           <= '0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out_last  <= 1'b0;
      io.sel_in    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        LOAD_KEY: begin
          if (io.in_valid) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (wp == WP_W'(i)) key[i] <= io.in_data;
            end
            if (wp == WP_W'(NBYTES - 1)) begin
              state <= LOAD_PT;
              wp    <= '0;
              busy  <= 1'b1;
            end else begin
              wp <= wp + WP_W'(1);
            end
          end
        end
        LOAD_PT: begin
          if (io.in_valid) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (wp == WP_W'(i)) pt[i] <= io.in_data;
            end
            if (wp == WP_W'(NBYTES - 1)) begin
              // Present pair 0 in the very next cycle.
              state        <= DRAIN;
              rp           <= '0;
              io.in_ready  <= 1'b0;
              io.out_valid <= 1'b1;
              io.sel_in    <= 1'b1;
              io.out_key   <= key[0];
              io.out_pt    <= pt[0];
              io.out_idx   <= '0;
              io.out_last  <= 1'b0;
            end else begin
              wp <= wp + WP_W'(1);
            end
          end
        end
        DRAIN: begin
          if (io.out_ready) begin
            if (rp == IDX_W'(NBYTES - 1)) begin
              state        <= LOAD_KEY;
              wp           <= '0;
              blk_cnt      <= blk_cnt + 8'd1;
              io.in_ready  <= 1'b1;
              io.out_valid <= 1'b0;
              io.sel_in    <= 1'b0;
              io.out_last  <= 1'b0;
              busy         <= 1'b0;
            end else begin
              rp          <= rp_nxt;
              io.out_key  <= key[rp_nxt];
              io.out_pt   <= pt[rp_nxt];
              io.out_idx  <= rp_nxt;
              io.out_last <= (rp_nxt == IDX_W'(NBYTES - 1));
            end
          end
        end
        default: state <= LOAD_KEY;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_byte_feeder.sv
// Randomised bench for aes_byte_feeder: a 32-byte stream model splits into key/plaintext
// halves and every drained pair, control flag and block count is compared against it.
module tb_aes_byte_feeder;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       busy;
  logic [7:0] blk_cnt;

  aes_byte_feeder_if bus ();

  aes_byte_feeder dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .io      (bus),
    .busy    (busy),
    .blk_cnt (blk_cnt)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  int         exp_blk = 0;
  logic [7:0] strm [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream model: bytes 0..15 are the key, 16..31 the plaintext.
  task automatic gen_stream(input bit seq);
    for (int i = 0; i < 32; i++) strm[i] = seq ? 8'(i) : 8'($urandom);
  endtask

  task automatic load_bytes(input int n, input int gap_pct);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 2000) begin
      @(negedge clk);
      check("load_in_ready", 32'(bus.in_ready), 32'd1);
      check("load_no_out_valid", 32'(bus.out_valid), 32'd0);
      check("load_busy", 32'(busy), 32'(i >= 16));
      bus.in_valid = (32'($urandom_range(99)) >= 32'(gap_pct));
      bus.in_data  = strm[i];
      @(posedge clk);
      if (bus.in_valid) i++;
      cyc++;
    end
    if (i < n) check("load_timeout", 32'(i), 32'(n));
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic drain_block(input int mode);
    int k = 0;
    int cyc = 0;
    while (k < 16 && cyc < 300) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("drain_out_valid", 32'(bus.out_valid), 32'd1);
      check("drain_sel_in", 32'(bus.sel_in), 32'd1);
      check("drain_in_ready", 32'(bus.in_ready), 32'd0);
      check("drain_busy", 32'(busy), 32'd1);
      check("drain_idx", 32'(bus.out_idx), 32'(k));
      check("drain_key", 32'(bus.out_key), 32'(strm[k]));
      check("drain_pt", 32'(bus.out_pt), 32'(strm[16 + k]));
      check("drain_last", 32'(bus.out_last), 32'(k == 15));
      check("drain_blk_cnt", 32'(blk_cnt), 32'(exp_blk));
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.out_ready = 1'($urandom_range(1));
      endcase
      @(posedge clk);
      if (bus.out_ready) k++;
      cyc++;
    end
    if (k < 16) check("drain_timeout", 32'(k), 32'd16);
    exp_blk = (exp_blk + 1) % 256;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_sel_in", 32'(bus.sel_in), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_last", 32'(bus.out_last), 32'd0);
    check("post_blk_cnt", 32'(blk_cnt), 32'(exp_blk));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_sel_in", 32'(bus.sel_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_key", 32'(bus.out_key), 32'd0);
    check("rst_out_pt", 32'(bus.out_pt), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    rst = 1'b0;

    // Sequential bytes, back-to-back, partner always ready.
    gen_stream(1'b1);
    load_bytes(32, 0);
    drain_block(0);

    // Downstream backpressure with the 1,0,0,1 pattern.
    gen_stream(1'b0);
    load_bytes(32, 0);
    drain_block(1);

    // Bubbly input and random backpressure.
    gen_stream(1'b0);
    load_bytes(32, 40);
    drain_block(2);

    // Flush after 20 bytes with a byte offered in the same cycle.
    gen_stream(1'b0);
    load_bytes(20, 30);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    flush        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_blk_cnt", 32'(blk_cnt), 32'(exp_blk));
    gen_stream(1'b0);
    load_bytes(32, 20);
    drain_block(0);

    // Asynchronous reset while pair 7 is presented.
    gen_stream(1'b0);
    load_bytes(32, 0);
    bus.out_ready = 1'b1;
    cyc = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (bus.out_idx != 4'd7 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("arst_reach_idx7", 32'(bus.out_idx), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_sel_in", 32'(bus.sel_in), 32'd0);
    check("arst_blk_cnt", 32'(blk_cnt), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    exp_blk = 0;
    #4 rst = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("arst_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_release_out_valid", 32'(bus.out_valid), 32'd0);

    // 256 blocks: the count must wrap 255 -> 0 with data still intact.
    for (int b = 0; b < 256; b++) begin
      gen_stream(1'b0);
      load_bytes(32, 0);
      drain_block(0);
    end
    check("wrap_blk_cnt", 32'(blk_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/aes_byte_feeder.md
# aes_byte_feeder

Byte-serial input stager for the 8-bit AES-128 datapath. It collects 16 key bytes and then 16 plaintext bytes over a valid/ready byte stream, and holds them in a 32-byte buffer. It then drains them as 16 aligned (key, plaintext) byte pairs into the round datapath's input byte muxes, driving the 2:1 select that chooses fresh input over round feedback. It sits directly upstream of the datapath byte multiplexers.

## Interface
- No parameters; widths are fixed: 8-bit bytes, 16-byte blocks.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  synchronous abort; returns the block to LOAD_KEY.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  byte pair available.
- out_ready  in  1  downstream accepts the pair when out_valid && out_ready.
- out_key  out  8  key byte of the current pair.
- out_pt  out  8  plaintext byte of the current pair.
- out_idx  out  4  byte index 0..15 of the current pair.
- out_last  out  1  high with out_valid when out_idx == 15.
- sel_in  out  1  mux 2:1 select; 1 = datapath takes fresh bytes, 0 = feedback.
- busy  out  1  high in LOAD_PT and DRAIN.
- blk_cnt  out  8  count of completed blocks.

## Operation
- The FSM has three states: LOAD_KEY, LOAD_PT, DRAIN. Reset state is LOAD_KEY.
- Byte order: byte 0 is the MSB of the 128-bit word (column-major AES state order).
- A single 5-bit write pointer wp is used in both load states.
- LOAD_KEY:
  - in_ready = 1.
  - Each accepted byte is written to key[wp] and wp increments.
  - When the byte at wp == 15 is accepted, move to LOAD_PT and set wp = 0.
- LOAD_PT:
  - in_ready = 1.
  - Each accepted byte is written to pt[wp] and wp increments.
  - When the byte at wp == 15 is accepted, move to DRAIN and set rp = 0.
- DRAIN:
  - in_ready = 0, out_valid = 1, sel_in = 1.
  - Outputs: out_key = key[rp], out_pt = pt[rp], out_idx = rp.
  - Each handshake increments rp.
  - The handshake at rp == 15 moves to LOAD_KEY, clears wp, and increments blk_cnt. blk_cnt wraps 255 -> 0.
- Outside DRAIN: out_valid = 0 and sel_in = 0. out_key, out_pt and out_idx hold their last values and are don't-care.
- Bytes offered while in_ready = 0 are not consumed; upstream must hold them.
- flush (synchronous, any state) forces LOAD_KEY and clears wp and rp.
  - Any byte handshake in that same cycle is discarded.
  - blk_cnt is unchanged.
  - The buffer contents are not cleared.
- flush has priority over every handshake in the same cycle.
- rst (asynchronous, any time, including mid-load or mid-drain) clears everything to reset values immediately.
- The buffer is flops: 32 × 8 bits. Each entry is written only by its own pointer match.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_last = 0, sel_in = 0, busy = 0.
  - out_key = 0, out_pt = 0, out_idx = 0, blk_cnt = 0.
  - wp = 0, rp = 0, buffer = 0.
- in_ready, out_valid, sel_in and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready.
- Latency: when the 32nd input byte is accepted in cycle N, out_valid = 1 in cycle N+1 with out_idx = 0.
- Throughput: one byte per cycle while loading and one pair per cycle while draining, when the partner is always ready.
- Minimum block period is 48 cycles: 32 load cycles plus 16 drain cycles.
- When the last pair is accepted in cycle M, in_ready = 1 in cycle M+1.
- out_ready low in DRAIN stalls the block. All outputs hold stable until the handshake completes.
- in_valid low in a load state stalls the block; wp holds.

## Test plan
- Reset then load:
  - Stimulus: rst pulse, then feed key bytes 0x00..0x0F and plaintext bytes 0x10..0x1F back-to-back.
  - Required: in_ready drops the cycle after byte 32 is accepted. Pair k is (key k, plaintext 0x10+k) with out_idx = k. out_last is high only at k = 15. blk_cnt = 1 after the drain.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1 repeatedly during DRAIN.
  - Required: no pair is dropped or duplicated, outputs are stable while stalled, and all 16 pairs arrive in order.
- Bubbly input:
  - Stimulus: random in_valid gaps during load.
  - Required: the buffer matches the stream. out_valid never rises before 32 bytes are accepted.
- Flush mid-PT:
  - Stimulus: assert flush after 20 bytes, with in_valid high in the same cycle.
  - Required: that byte is discarded. The state returns to LOAD_KEY (busy = 0). A fresh 32-byte load drains correctly. blk_cnt is unchanged by the flush.
- Async reset mid-drain:
  - Stimulus: assert rst at out_idx = 7, asynchronously to clk.
  - Required: out_valid = 0, sel_in = 0 and blk_cnt = 0 immediately. After release, in_ready = 1.
- Counter wrap:
  - Stimulus: run 256 blocks.
  - Required: blk_cnt goes 255 -> 0 on the 256th block; data pairs are still correct.
